lvds_rx_align: RTL and testbench

- Word-alignment controller for one sensor LVDS data lane on the receive side.
- Counterpart to the transmit-side serializer, which is paced by tx_strobe on clk_txg/clk_txio.
- Watches deserialized DW-bit words in the clk_rxg domain during sensor training.
- Pulses the deserializer bitslip until the training word is seen repeatedly, then declares lock and forwards pixel words to the capture path.

---
 rtl/lvds_rx_pkg.sv | 21 ++
 rtl/lvds_rx_align.sv | 188 ++++++++++++++++++
 tb/tb_lvds_rx_align.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_rx_pkg.sv
// Shared definitions for the LVDS receive word-alignment logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lvds_rx_pkg;

    // Default lane word width (10-bit HDR pixels).
    localparam int LVDS_DW = 10;

    // Pattern the sensor repeats while training.
    localparam logic [LVDS_DW-1:0] LVDS_TRAIN_WORD = 10'h3A5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_WAIT,
        ST_LOCKED,
        ST_FAIL
    } align_state_t;

endpackage

// File: rtl/lvds_rx_align.sv
// Word-alignment controller for one sensor LVDS lane: bitslips the deserializer until TRAIN_WORD repeats, then locks.
// Latency: dout/dout_vld are din/din_vld registered once; aligned follows the internal lock state by one cycle.
// Backpressure: none; the lane cannot be stalled, din_vld=0 cycles simply hold the search counters.
//
// Ports:
//   clk_rxg, rst_sys_n      receive word clock, async active-low reset
//   train_en, realign       sensor-is-training level, one-cycle restart request
//   din, din_vld            deserialized word and its valid
//   bitslip                 one-cycle pulse to the deserializer
//   aligned, align_err      lane locked / search exhausted without lock
//   slip_cnt                bitslips issued in the current search
//   dout, dout_vld          registered word, valid only while locked
module lvds_rx_align
    import lvds_rx_pkg::*;
#(
    parameter int              DW         = LVDS_DW,
    parameter logic [DW-1:0]   TRAIN_WORD = LVDS_TRAIN_WORD,
    parameter int              LOCK_CNT   = 16,
    parameter int              SLIP_WAIT  = 4,
    parameter int              LOSS_CNT   = 4
) (
    input  logic                     clk_rxg,
    input  logic                     rst_sys_n,
    input  logic                     train_en,
    input  logic                     realign,
    input  logic [DW-1:0]            din,
    input  logic                     din_vld,
    output logic                     bitslip,
    output logic                     aligned,
    output logic                     align_err,
    output logic [$clog2(DW+1)-1:0]  slip_cnt,
    output logic [DW-1:0]            dout,
    output logic                     dout_vld
);

    localparam int SW = $clog2(DW + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);

    // DW slips cover every rotation, so a mismatch seen with slip_cnt==DW ends the search.
    localparam logic [SW-1:0] SLIP_MAX   = SW'(DW);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(SLIP_WAIT - 1);
    localparam logic [LW-1:0] LOSS_LAST  = LW'(LOSS_CNT - 1);

    align_state_t    state_q,     state_d;
    logic [SW-1:0]   slip_cnt_q,  slip_cnt_d;
    logic [MW-1:0]   match_cnt_q, match_cnt_d;
    logic [LW-1:0]   miss_cnt_q,  miss_cnt_d;
    logic [WW-1:0]   wait_cnt_q,  wait_cnt_d;
    logic            aligned_q,   aligned_d;
    logic            align_err_q, align_err_d;
    logic [DW-1:0]   dout_q,      dout_d;
    logic            dout_vld_q,  dout_vld_d;

    logic            word_match;
    logic            lock_loss;

    assign word_match = (din == TRAIN_WORD);

    // The LOSS_CNT-th consecutive valid mismatch while the sensor is still training.
    assign lock_loss  = train_en && din_vld && !word_match && (miss_cnt_q == LOSS_LAST);

    always_comb begin
        state_d     = state_q;
        slip_cnt_d  = slip_cnt_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        wait_cnt_d  = wait_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (train_en) begin
                    state_d     = ST_CHECK;
                    slip_cnt_d  = '0;
                    match_cnt_d = '0;
                end
            end

            ST_CHECK: begin
                if (!train_en) begin
                    state_d = ST_IDLE;
                end else if (realign) begin
                    slip_cnt_d  = '0;
                    match_cnt_d = '0;
                end else if (din_vld) begin
                    if (word_match) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_q == MATCH_LAST) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        match_cnt_d = '0;
                        state_d     = (slip_cnt_q == SLIP_MAX) ? ST_FAIL : ST_SLIP;
                    end
                end
            end

            // The pulse in this cycle always completes; an abort only changes where we go next.
            ST_SLIP: begin
                slip_cnt_d = slip_cnt_q + 1'b1;
                wait_cnt_d = '0;
                state_d    = train_en ? ST_WAIT : ST_IDLE;
            end

            // Give the deserializer time to settle; runs on clock cycles, not valid words.
            ST_WAIT: begin
                if (!train_en) begin
                    state_d = ST_IDLE;
                end else if (realign) begin
                    state_d     = ST_CHECK;
                    slip_cnt_d  = '0;
                    match_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            ST_LOCKED: begin
                if (realign || lock_loss) begin
                    state_d     = ST_CHECK;
                    slip_cnt_d  = '0;
                    match_cnt_d = '0;
                    miss_cnt_d  = '0;
                end else if (!train_en) begin
                    // Live pixel data: nothing to compare against.
                    miss_cnt_d = '0;
                end else if (din_vld) begin
                    miss_cnt_d = word_match ? '0 : miss_cnt_q + 1'b1;
                end
            end

            ST_FAIL: begin
                if (!train_en) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        aligned_d   = (state_q == ST_LOCKED);
        align_err_d = (state_q == ST_FAIL);
        dout_d      = din;
        dout_vld_d  = din_vld && (state_q == ST_LOCKED);
    end

    always_ff @(posedge clk_rxg or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q     <= ST_IDLE;
            slip_cnt_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            aligned_q   <= 1'b0;
            align_err_q <= 1'b0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            slip_cnt_q  <= slip_cnt_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            aligned_q   <= aligned_d;
            align_err_q <= align_err_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
        end
    end

    // Decoded straight from the state flop so reset kills an in-flight pulse immediately.
    assign bitslip   = (state_q == ST_SLIP);
    assign aligned   = aligned_q;
    assign align_err = align_err_q;
    assign slip_cnt  = slip_cnt_q;
    assign dout      = dout_q;
    assign dout_vld  = dout_vld_q;

endmodule

// File: tb/tb_lvds_rx_align.sv
// Bench for lvds_rx_align: a lane model whose word rotation drops by one per bitslip,
// plus a search/lock reference predicting bitslip, aligned, align_err, slip_cnt, dout, dout_vld.
// Inputs change on the falling edge; outputs are compared there too.
module tb_lvds_rx_align;

    localparam int          DW        = 10;
    localparam logic [9:0]  TW        = 10'h3A5;
    localparam int          LOCK_CNT  = 16;
    localparam int          SLIP_WAIT = 4;
    localparam int          LOSS_CNT  = 4;

    logic        clk_rxg;
    logic        rst_sys_n;
    logic        train_en;
    logic        realign;
    logic [9:0]  din;
    logic        din_vld;
    logic        bitslip;
    logic        aligned;
    logic        align_err;
    logic [3:0]  slip_cnt;
    logic [9:0]  dout;
    logic        dout_vld;

    lvds_rx_align #(
        .DW         (DW),
        .TRAIN_WORD (TW),
        .LOCK_CNT   (LOCK_CNT),
        .SLIP_WAIT  (SLIP_WAIT),
        .LOSS_CNT   (LOSS_CNT)
    ) dut (
        .clk_rxg    (clk_rxg),
        .rst_sys_n  (rst_sys_n),
        .train_en   (train_en),
        .realign    (realign),
        .din        (din),
        .din_vld    (din_vld),
        .bitslip    (bitslip),
        .aligned    (aligned),
        .align_err  (align_err),
        .slip_cnt   (slip_cnt),
        .dout       (dout),
        .dout_vld   (dout_vld)
    );

    initial clk_rxg = 1'b0;
    always #5 clk_rxg = ~clk_rxg;

    int n_err;
    int n_checks;
    int cyc;

    // Lane model
    int rot;
    int din_mode;      // 0: rotated training word, 1: stuck at zero

    // Reference: mode 0 idle, 1 searching, 2 locked, 3 given up
    int   m_mode;
    int   m_cmp_from;  // first cycle whose valid word is compared after a slip
    int   m_run;
    int   m_slips;
    int   m_miss;
    int   m_slip_cycle;
    bit   m_prev_locked;
    bit   m_prev_failed;
    bit   prev_vld;
    logic [9:0] prev_din;

    // Bitslip observation
    int bs_count;
    int last_bs;
    int min_gap;

    int k;
    int e_cyc;
    int rise_cyc;
    int rot0;

    function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
        logic [19:0] d;
        d = {w, w};
        return d[19 - r -: 10];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode        = 0;
        m_cmp_from    = 0;
        m_run         = 0;
        m_slips       = 0;
        m_miss        = 0;
        m_slip_cycle  = -1;
        m_prev_locked = 1'b0;
        m_prev_failed = 1'b0;
        prev_vld      = 1'b0;
        prev_din      = din;
    endtask

    task automatic bs_reset();
        bs_count = 0;
        last_bs  = -1;
        min_gap  = 1000;
    endtask

    // One clock cycle: check what the DUT shows now, drive this cycle's inputs,
    // advance the reference, then move to the next falling edge.
    task automatic step(input bit te, input bit ra, input bit v, input bit bad);
        bit         e_bs;
        bit         e_al;
        bit         e_er;
        bit         match;
        int         old_mode;
        logic [9:0] w;

        e_bs = (cyc == m_slip_cycle);
        e_al = m_prev_locked;
        e_er = m_prev_failed;
        chk("bitslip",   {31'd0, bitslip},   {31'd0, e_bs});
        chk("aligned",   {31'd0, aligned},   {31'd0, e_al});
        chk("align_err", {31'd0, align_err}, {31'd0, e_er});
        chk("dout",      {22'd0, dout},      {22'd0, prev_din});
        chk("dout_vld",  {31'd0, dout_vld},  {31'd0, prev_vld & e_al});
        if (e_al || e_er)
            chk("slip_cnt", {28'd0, slip_cnt}, m_slips);

        if (bitslip === 1'b1) begin
            bs_count++;
            if (last_bs >= 0 && (cyc - last_bs) < min_gap)
                min_gap = cyc - last_bs;
            last_bs = cyc;
            rot = (rot + DW - 1) % DW;
        end

        w = (din_mode == 1) ? 10'h000 : rotl(TW, rot);
        if (bad) w = w ^ 10'h001;
        if (!te) w = 10'($urandom);
        train_en = te;
        realign  = ra;
        din_vld  = v;
        din      = w;
        match    = (w == TW);

        old_mode = m_mode;
        case (m_mode)
            0: if (te) begin
                m_mode = 1; m_cmp_from = cyc + 1; m_run = 0; m_slips = 0;
            end
            1: begin
                if (!te) begin
                    m_mode = 0;
                end else if (ra && cyc != m_slip_cycle) begin
                    m_cmp_from = cyc + 1; m_run = 0; m_slips = 0;
                end else if (cyc >= m_cmp_from && v) begin
                    if (match) begin
                        m_run++;
                        if (m_run == LOCK_CNT) begin
                            m_mode = 2; m_miss = 0;
                        end
                    end else begin
                        m_run = 0;
                        if (m_slips == DW) begin
                            m_mode = 3;
                        end else begin
                            m_slips++;
                            m_slip_cycle = cyc + 1;
                            m_cmp_from   = cyc + 2 + SLIP_WAIT;
                        end
                    end
                end
            end
            2: begin
                if (ra || (te && v && !match && m_miss == LOSS_CNT - 1)) begin
                    m_mode = 1; m_cmp_from = cyc + 1; m_run = 0; m_slips = 0; m_miss = 0;
                end else if (!te) begin
                    m_miss = 0;
                end else if (v) begin
                    m_miss = match ? 0 : m_miss + 1;
                end
            end
            default: if (!te) m_mode = 0;
        endcase
        m_prev_locked = (old_mode == 2);
        m_prev_failed = (old_mode == 3);
        prev_din      = w;
        prev_vld      = v;

        @(negedge clk_rxg);
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_err = 0; n_checks = 0; cyc = 0; rot = 0; din_mode = 0;
        rst_sys_n = 1'b0; train_en = 1'b0; realign = 1'b0; din = '0; din_vld = 1'b0;
        model_reset();
        bs_reset();

        // Reset state
        #1;
        chk("rst_bitslip",   {31'd0, bitslip},   0);
        chk("rst_aligned",   {31'd0, aligned},   0);
        chk("rst_align_err", {31'd0, align_err}, 0);
        chk("rst_slip_cnt",  {28'd0, slip_cnt},  0);
        chk("rst_dout",      {22'd0, dout},      0);
        chk("rst_dout_vld",  {31'd0, dout_vld},  0);
        @(negedge clk_rxg); @(negedge clk_rxg);
        rst_sys_n = 1'b1;
        step(0, 0, 0, 0);

        // Lane starts rotated by 3, words arrive with random gaps
        rot = 3; bs_reset();
        k = 0;
        while (m_mode != 2 && k < 600) begin
            step(1, 0, ($urandom_range(0, 99) < 80), 0);
            k++;
        end
        step(1, 0, 1, 0); step(1, 0, 1, 0);
        chk("rot3_aligned",  {31'd0, aligned}, 1);
        chk("rot3_slip_cnt", {28'd0, slip_cnt}, 3);
        chk("rot3_bitslips", bs_count, 3);
        chk("rot3_spacing",  {31'd0, (min_gap >= SLIP_WAIT + 2)}, 1);

        // Three misses then a match keeps lock
        repeat (3) step(1, 0, 1, 1);
        step(1, 0, 1, 0);
        repeat (4) step(1, 0, 1, 0);
        chk("miss3_still_aligned", {31'd0, aligned}, 1);

        // Four consecutive misses drop lock and restart from slip_cnt 0
        repeat (4) step(1, 0, 1, 1);
        step(1, 0, 1, 0);
        chk("loss_aligned",  {31'd0, aligned}, 0);
        chk("loss_slip_cnt", {28'd0, slip_cnt}, 0);
        k = 0;
        while (m_mode != 2 && k < 100) begin step(1, 0, 1, 0); k++; end
        step(1, 0, 1, 0); step(1, 0, 1, 0);
        chk("relock_aligned", {31'd0, aligned}, 1);

        // realign coinciding with the fourth miss
        repeat (3) step(1, 0, 1, 1);
        step(1, 1, 1, 1);
        step(1, 0, 1, 0); step(1, 0, 1, 0);
        chk("realign_loss_aligned", {31'd0, aligned}, 0);
        k = 0;
        while (m_mode != 2 && k < 100) begin step(1, 0, 1, 0); k++; end

        // Back to idle, then a clean start at rotation 0 with valid every cycle:
        // CHECK is entered one cycle after train_en is seen, 16 matches, then one more cycle for aligned.
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        bs_reset();
        e_cyc = cyc; rise_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            if (aligned === 1'b1) begin rise_cyc = cyc; break; end
            step(1, 0, 1, 0);
        end
        chk("rot0_lock_latency", rise_cyc - e_cyc, 1 + LOCK_CNT + 1);
        chk("rot0_slip_cnt",     {28'd0, slip_cnt}, 0);
        chk("rot0_bitslips",     bs_count, 0);

        // Valid toggling every other cycle during the search
        step(1, 1, 0, 0);
        e_cyc = cyc;
        k = 0;
        while (m_mode != 2 && k < 100) begin step(1, 0, cyc[0], 0); k++; end
        chk("toggle_lock_cycles", {31'd0, ((cyc - e_cyc) >= 2 * LOCK_CNT - 1)}, 1);
        step(1, 0, 1, 0); step(1, 0, 0, 0);
        chk("toggle_aligned", {31'd0, aligned}, 1);

        // Live pixel data while locked: dout_vld follows din_vld
        for (int i = 0; i < 24; i++) step(0, 0, ($urandom_range(0, 1) == 1), 0);
        chk("pixel_aligned", {31'd0, aligned}, 1);

        // Random misalignment, random valid gaps
        rot0 = $urandom_range(1, 9);
        rot = rot0; bs_reset();
        step(1, 1, 1, 0);
        k = 0;
        while (m_mode != 2 && k < 800) begin
            step(1, 0, ($urandom_range(0, 99) < 70), 0);
            k++;
        end
        step(1, 0, 1, 0); step(1, 0, 1, 0);
        chk("rand_aligned",  {31'd0, aligned}, 1);
        chk("rand_slip_cnt", {28'd0, slip_cnt}, rot0);
        chk("rand_bitslips", bs_count, rot0);

        // Stuck lane: every rotation tried, then give up
        din_mode = 1; bs_reset();
        step(1, 1, 1, 0);
        k = 0;
        while (m_mode != 3 && k < 400) begin step(1, 0, 1, 0); k++; end
        step(1, 0, 1, 0); step(1, 0, 1, 0);
        chk("stuck_align_err", {31'd0, align_err}, 1);
        chk("stuck_aligned",   {31'd0, aligned},   0);
        chk("stuck_bitslips",  bs_count, DW);
        chk("stuck_slip_cnt",  {28'd0, slip_cnt}, DW);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        chk("fail_cleared", {31'd0, align_err}, 0);
        din_mode = 0;
        repeat (2) step(0, 0, 0, 0);

        // Reset while waiting after the second slip
        rot = 5; bs_reset();
        k = 0;
        while (bs_count < 2 && k < 100) begin step(1, 0, 1, 0); k++; end
        step(1, 0, 1, 0);
        #2;
        rst_sys_n = 1'b0;
        #1;
        chk("midrst_bitslip",   {31'd0, bitslip},   0);
        chk("midrst_aligned",   {31'd0, aligned},   0);
        chk("midrst_align_err", {31'd0, align_err}, 0);
        chk("midrst_slip_cnt",  {28'd0, slip_cnt},  0);
        chk("midrst_dout_vld",  {31'd0, dout_vld},  0);
        train_en = 1'b0; realign = 1'b0; din_vld = 1'b0; din = '0;
        @(negedge clk_rxg); cyc++;
        @(negedge clk_rxg); cyc++;
        rst_sys_n = 1'b1;
        model_reset();
        bs_reset();
        chk("postrst_slip_cnt", {28'd0, slip_cnt}, 0);
        k = 0;
        while (m_mode != 2 && k < 300) begin step(1, 0, 1, 0); k++; end
        step(1, 0, 1, 0); step(1, 0, 1, 0);
        chk("postrst_aligned",  {31'd0, aligned}, 1);
        chk("postrst_slip_cnt_lock", {28'd0, slip_cnt}, 3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
